// File: rtl/unidade_regras_seq.sv
// Rule-walk sequencer for the 3x3 fuzzy rule base: drives antecedent selects, consequent
// readback and one-hot write strobes. Optional macro UNIDADE_REGRAS_SKIP_EN skips code-3 rules.
module unidade_regras_seq #(
  parameter int N_ANT = 3,
  parameter int PW    = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic [17:0]     rule_map,
  output logic [1:0]      sel_2,
  output logic [1:0]      sel_1,
  output logic [1:0]      mux_8canais,
  output logic [PW-1:0]   pos_men,
  output logic            clr_out,
  output logic            busy,
  output logic            done
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_APPLY = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [1:0] LAST_IDX = 2'(N_ANT - 1);
  localparam logic [1:0] CODE_OFF = 2'd3;

  state_t       state_r;
  logic [17:0]  map_r;
  logic [1:0]   i_r;
  logic [1:0]   j_r;

  logic [3:0]   k_s;
  logic [1:0]   cur_code_s;
  logic         first_none_s;
  logic [1:0]   first_i_s;
  logic [1:0]   first_j_s;
  logic [1:0]   first_code_s;
  logic         adv_last_s;
  logic [1:0]   adv_i_s;
  logic [1:0]   adv_j_s;
  logic [1:0]   adv_code_s;

  function automatic logic [3:0] k_of(input logic [1:0] i, input logic [1:0] j);
    return ({2'b00, i} * 4'd3) + {2'b00, j};
  endfunction

  function automatic logic [1:0] code_at(input logic [17:0] map, input logic [3:0] k);
    logic [17:0] sh;
    sh = map >> {k, 1'b0};
    return sh[1:0];
  endfunction

  function automatic logic [PW-1:0] strobe(input logic [1:0] code);
    logic [PW-1:0] r;
    r = '0;
    if (code != CODE_OFF) begin
      r[code] = 1'b1;
    end else begin
      r = '0;
    end
    return r;
  endfunction

`ifdef UNIDADE_REGRAS_SKIP_EN
  localparam logic [3:0] K_NONE = 4'd9;

  logic [3:0] first_k_s;
  logic [3:0] adv_k_s;

  // Lowest enabled rule index at or after 'from'; K_NONE when none remain.
  function automatic logic [3:0] next_enabled(input logic [17:0] map, input logic [3:0] from);
    logic [3:0] r;
    r = K_NONE;
    for (int k = 8; k >= 0; k--) begin
      if ((4'(k) >= from) && (map[2*k +: 2] != CODE_OFF)) begin
        r = 4'(k);
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  function automatic logic [1:0] i_of(input logic [3:0] k);
    case (k)
      4'd0, 4'd1, 4'd2: return 2'd0;
      4'd3, 4'd4, 4'd5: return 2'd1;
      4'd6, 4'd7, 4'd8: return 2'd2;
      default:          return 2'd0;
    endcase
  endfunction

  function automatic logic [1:0] j_of(input logic [3:0] k);
    case (k)
      4'd0, 4'd3, 4'd6: return 2'd0;
      4'd1, 4'd4, 4'd7: return 2'd1;
      4'd2, 4'd5, 4'd8: return 2'd2;
      default:          return 2'd0;
    endcase
  endfunction
`endif

  // Rule-index arithmetic: current code, first rule after CLEAR, and the rule after this WRITE.
  always_comb begin
    k_s        = k_of(i_r, j_r);
    cur_code_s = code_at(map_r, k_s);
`ifdef UNIDADE_REGRAS_SKIP_EN
    first_k_s    = next_enabled(map_r, 4'd0);
    adv_k_s      = next_enabled(map_r, k_s + 4'd1);
    first_none_s = (first_k_s == K_NONE);
    adv_last_s   = (adv_k_s == K_NONE);
    first_i_s    = i_of(first_k_s);
    first_j_s    = j_of(first_k_s);
    adv_i_s      = i_of(adv_k_s);
    adv_j_s      = j_of(adv_k_s);
`else
    first_none_s = 1'b0;
    first_i_s    = 2'd0;
    first_j_s    = 2'd0;
    adv_last_s   = (i_r == LAST_IDX) && (j_r == LAST_IDX);
    if (j_r == LAST_IDX) begin
      adv_j_s = 2'd0;
      if (i_r == LAST_IDX) begin
        adv_i_s = 2'd0;
      end else begin
        adv_i_s = i_r + 2'd1;
      end
    end else begin
      adv_i_s = i_r;
      adv_j_s = j_r + 2'd1;
    end
`endif
    first_code_s = code_at(map_r, k_of(first_i_s, first_j_s));
    adv_code_s   = code_at(map_r, k_of(adv_i_s, adv_j_s));
  end

  // Sequencer FSM with every control output registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      map_r       <= 18'd0;
      i_r         <= 2'd0;
      j_r         <= 2'd0;
      sel_2       <= 2'd0;
      sel_1       <= 2'd0;
      mux_8canais <= 2'd0;
      pos_men     <= '0;
      clr_out     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (!abort && start) begin
            state_r <= ST_CLEAR;
            map_r   <= rule_map;
            i_r     <= 2'd0;
            j_r     <= 2'd0;
            clr_out <= 1'b1;
            busy    <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_CLEAR: begin
          clr_out <= 1'b0;
          if (abort) begin
            state_r <= ST_IDLE;
            busy    <= 1'b0;
          end else if (first_none_s) begin
            state_r <= ST_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            state_r     <= ST_APPLY;
            i_r         <= first_i_s;
            j_r         <= first_j_s;
            sel_2       <= first_i_s;
            sel_1       <= first_j_s;
            mux_8canais <= first_code_s;
            pos_men     <= '0;
          end
        end
        ST_APPLY: begin
          if (abort) begin
            state_r     <= ST_IDLE;
            sel_2       <= 2'd0;
            sel_1       <= 2'd0;
            mux_8canais <= 2'd0;
            pos_men     <= '0;
            busy        <= 1'b0;
          end else begin
            state_r <= ST_WRITE;
            pos_men <= strobe(cur_code_s);
          end
        end
        ST_WRITE: begin
          pos_men <= '0;
          if (abort || adv_last_s) begin
            // abort and end-of-walk share the cleanup; only the latter reaches DONE.
            state_r     <= abort ? ST_IDLE : ST_DONE;
            done        <= !abort;
            sel_2       <= 2'd0;
            sel_1       <= 2'd0;
            mux_8canais <= 2'd0;
            busy        <= 1'b0;
          end else begin
            state_r     <= ST_APPLY;
            i_r         <= adv_i_s;
            j_r         <= adv_j_s;
            sel_2       <= adv_i_s;
            sel_1       <= adv_j_s;
            mux_8canais <= adv_code_s;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          done    <= 1'b0;
        end
        default: begin
          state_r     <= ST_IDLE;
          sel_2       <= 2'd0;
          sel_1       <= 2'd0;
          mux_8canais <= 2'd0;
          pos_men     <= '0;
          clr_out     <= 1'b0;
          busy        <= 1'b0;
          done        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_unidade_regras_seq.sv
// Directed bench for unidade_regras_seq; honours UNIDADE_REGRAS_SKIP_EN when defined.
module tb_unidade_regras_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [17:0] rule_map;
  logic [1:0]  sel_2;
  logic [1:0]  sel_1;
  logic [1:0]  mux_8canais;
  logic [3:0]  pos_men;
  logic        clr_out;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;

  unidade_regras_seq #(.N_ANT(3), .PW(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .rule_map    (rule_map),
    .sel_2       (sel_2),
    .sel_1       (sel_1),
    .mux_8canais (mux_8canais),
    .pos_men     (pos_men),
    .clr_out     (clr_out),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] outs();
    return {3'b000, busy, clr_out, done, sel_2, sel_1, mux_8canais, pos_men};
  endfunction

  function automatic logic [15:0] ev(input logic b, input logic c, input logic d,
                                     input logic [1:0] s2, input logic [1:0] s1,
                                     input logic [1:0] m, input logic [3:0] p);
    return {3'b000, b, c, d, s2, s1, m, p};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One pass: per-rule APPLY/WRITE checks, done cycle index, optional live map change and start pokes.
  task automatic run_pass(input logic [17:0] map, input int exp_len, input int chg_k,
                          input logic [17:0] new_map, input logic poke);
    int          cyc;
    logic [1:0]  code;
    logic [17:0] m;
    m        = map;
    rule_map = map;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    cyc      = 1;
    chk("clear", outs(), ev(1'b1, 1'b1, 1'b0, 2'd0, 2'd0, 2'd0, 4'b0000));
    for (int k = 0; k < 9; k++) begin
      code = m[2*k +: 2];
`ifdef UNIDADE_REGRAS_SKIP_EN
      if (code == 2'd3) continue;
`endif
      if (k == chg_k) begin
        rule_map = new_map;
        start    = poke;
      end
      tick();
      cyc++;
      start = 1'b0;
      chk("apply", outs(), ev(1'b1, 1'b0, 1'b0, 2'(k / 3), 2'(k % 3), code, 4'b0000));
      tick();
      cyc++;
      chk("write", outs(), ev(1'b1, 1'b0, 1'b0, 2'(k / 3), 2'(k % 3), code,
                              (code == 2'd3) ? 4'b0000 : 4'(1 << code)));
    end
    tick();
    cyc++;
    chk("done", outs(), ev(1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 2'd0, 4'b0000));
    chk("len", 16'(cyc), 16'(exp_len));
    start = poke;
    tick();
    start = 1'b0;
    chk("idle", outs(), 16'h0000);
  endtask

  initial begin
    logic seen;
    rst      = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    rule_map = 18'h00000;
    #12;
    chk("rst_outs", outs(), 16'h0000);
    @(posedge clk);
    #1 rst = 1'b1;
    tick();
    chk("idle_after_rst", outs(), 16'h0000);

    // codes 0,1,2 repeating; start pokes mid-pass and in DONE are ignored
    run_pass(18'h24924, 20, 3, 18'h24924, 1'b1);

    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    chk("abort_wins", outs(), 16'h0000);
    tick();
    chk("abort_wins2", outs(), 16'h0000);

    // live map switched to all-2 during the pass; writes must stay on slot 0
    run_pass(18'h00000, 20, 2, 18'h2AAAA, 1'b0);

`ifdef UNIDADE_REGRAS_SKIP_EN
    run_pass(18'h3FFFF, 2, 99, 18'h00000, 1'b0);
    run_pass(18'h33FDF, 6, 99, 18'h00000, 1'b0);
`else
    run_pass(18'h3FFFF, 20, 99, 18'h00000, 1'b0);
    run_pass(18'h33FDF, 20, 99, 18'h00000, 1'b0);
`endif

    // abort during APPLY of rule 5 (cycle t0+12)
    rule_map = 18'h24924;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    for (int c = 2; c <= 12; c++) begin
      tick();
      start = (c == 4);
    end
    chk("apply_k5", outs(), ev(1'b1, 1'b0, 1'b0, 2'd1, 2'd2, 2'd2, 4'b0000));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_idle", outs(), 16'h0000);
    seen = 1'b0;
    for (int c = 0; c < 25; c++) begin
      tick();
      if (done || clr_out || busy) seen = 1'b1;
    end
    chk("no_done_after_abort", {15'd0, seen}, 16'h0000);

    // reset asserted mid-WRITE of rule 4 (cycle t0+11)
    rule_map = 18'h24924;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    for (int c = 2; c <= 11; c++) tick();
    chk("write_k4", outs(), ev(1'b1, 1'b0, 1'b0, 2'd1, 2'd1, 2'd1, 4'b0010));
    #2 rst = 1'b0;
    #1;
    chk("async_rst", outs(), 16'h0000);
    @(posedge clk);
    #1 rst = 1'b1;
    tick();
    run_pass(18'h24924, 20, 99, 18'h00000, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
